// File: rtl/sisc_ctrl_pkg.sv
// Shared constants for the SISC multi-cycle control unit:
// opcodes, FSM state encoding and ALU override codes.
package sisc_ctrl_pkg;

    localparam int OP_W = 4;
    localparam int MM_W = 4;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ALUR = 4'h1;
    localparam logic [3:0] OP_ADDI = 4'h2;
    localparam logic [3:0] OP_LOD  = 4'h3;
    localparam logic [3:0] OP_STR  = 4'h4;
    localparam logic [3:0] OP_BRA  = 4'h5;
    localparam logic [3:0] OP_BRR  = 4'h6;
    localparam logic [3:0] OP_HLT  = 4'hF;

    localparam logic [1:0] ALUOP_RR   = 2'b00;
    localparam logic [1:0] ALUOP_RI   = 2'b01;
    localparam logic [1:0] ALUOP_NOST = 2'b10;
    localparam logic [1:0] ALUOP_ADDR = 2'b11;

    typedef enum logic [2:0] {
        S_START0    = 3'd0,
        S_START1    = 3'd1,
        S_FETCH     = 3'd2,
        S_DECODE    = 3'd3,
        S_EXECUTE   = 3'd4,
        S_MEM       = 3'd5,
        S_WRITEBACK = 3'd6,
        S_HALT      = 3'd7
    } state_e;

    // ALU override used while EXECUTE/MEM are active.
    function automatic logic [1:0] alu_op_of(input logic [3:0] op);
        logic [1:0] r;
        r = ALUOP_NOST;
        if (op == OP_ALUR) r = ALUOP_RR;
        else if (op == OP_ADDI) r = ALUOP_RI;
        else if (op == OP_LOD || op == OP_STR) r = ALUOP_ADDR;
        return r;
    endfunction

endpackage

// File: rtl/sisc_ctrl_if.sv
// Controller <-> datapath bundle: IR/ALU status inputs to the
// controller and every datapath strobe it drives back.
interface sisc_ctrl_if;
    logic [31:0] instr;
    logic [3:0]  stat_in;
    logic        stat_en_in;
    logic [1:0]  alu_op;
    logic        ir_load;
    logic        pc_write;
    logic        pc_sel;
    logic        br_sel;
    logic        rb_sel;
    logic        rf_we;
    logic        wb_sel;
    logic        dm_we;
    logic [3:0]  status_q;
    logic        halted;

    modport master (
        input  instr, stat_in, stat_en_in,
        output alu_op, ir_load, pc_write, pc_sel, br_sel,
        output rb_sel, rf_we, wb_sel, dm_we, status_q, halted
    );

    modport slave (
        output instr, stat_in, stat_en_in,
        input  alu_op, ir_load, pc_write, pc_sel, br_sel,
        input  rb_sel, rf_we, wb_sel, dm_we, status_q, halted
    );
endinterface

// File: rtl/sisc_br_cond.sv
// Branch condition: take when mask is zero (unconditional)
// or any masked status flag is set. Ports: mm, status_q -> take.
module sisc_br_cond
    import sisc_ctrl_pkg::*;
#(
    parameter int MM_W = 4
) (
    input  logic [MM_W-1:0] mm,
    input  logic [MM_W-1:0] status_q,
    output logic            take
);

    assign take = (mm == '0) | (|(mm & status_q));

endmodule

// File: rtl/sisc_ctrl.sv
// SISC multi-cycle control FSM, status register and strobe decode.
// Ports: clk, rst_f (async active-low), bus (sisc_ctrl_if.master).
module sisc_ctrl
    import sisc_ctrl_pkg::*;
#(
    parameter int OP_W = 4,
    parameter int MM_W = 4
) (
    input  logic         clk,
    input  logic         rst_f,
    sisc_ctrl_if.master  bus
);

    state_e            state_q, state_d;
    logic [3:0]        status_q, status_d;
    logic              br_taken_q, br_taken_d;
    logic [OP_W-1:0]   opcode;
    logic [MM_W-1:0]   mm;
    logic              take;

    logic [1:0] alu_op;
    logic       ir_load, pc_write, pc_sel, br_sel;
    logic       rb_sel, rf_we, wb_sel, dm_we, halted;

    assign opcode = bus.instr[31 -: OP_W];
    assign mm     = bus.instr[27 -: MM_W];

    sisc_br_cond #(.MM_W(MM_W)) u_br_cond (
        .mm       (mm),
        .status_q (status_q),
        .take     (take)
    );

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            state_q    <= S_START0;
            status_q   <= '0;
            br_taken_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            status_q   <= status_d;
            br_taken_q <= br_taken_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        status_d   = status_q;
        br_taken_d = br_taken_q;
        alu_op     = ALUOP_RR;
        ir_load    = 1'b0;
        pc_write   = 1'b0;
        pc_sel     = 1'b0;
        br_sel     = 1'b0;
        rb_sel     = 1'b0;
        rf_we      = 1'b0;
        wb_sel     = 1'b0;
        dm_we      = 1'b0;
        halted     = 1'b0;
        unique case (state_q)
            S_START0: state_d = S_START1;
            S_START1: state_d = S_FETCH;
            S_FETCH: begin
                ir_load  = 1'b1;
                pc_write = 1'b1;
                state_d  = S_DECODE;
            end
            S_DECODE: begin
                // Registered here so EXECUTE sees a stable decision.
                br_taken_d = take;
                state_d    = (opcode == OP_HLT) ? S_HALT : S_EXECUTE;
            end
            S_EXECUTE: begin
                alu_op = alu_op_of(opcode);
                if (opcode == OP_ALUR && bus.stat_en_in)
                    status_d = bus.stat_in;
                rb_sel = (opcode == OP_STR);
                if ((opcode == OP_BRA || opcode == OP_BRR) && br_taken_q) begin
                    pc_write = 1'b1;
                    pc_sel   = 1'b1;
                    br_sel   = (opcode == OP_BRR);
                end
                state_d = S_MEM;
            end
            S_MEM: begin
                alu_op  = alu_op_of(opcode);
                rb_sel  = (opcode == OP_STR);
                dm_we   = (opcode == OP_STR);
                state_d = S_WRITEBACK;
            end
            S_WRITEBACK: begin
                rf_we   = (opcode == OP_ALUR) || (opcode == OP_ADDI) ||
                          (opcode == OP_LOD);
                wb_sel  = (opcode == OP_LOD);
                state_d = S_FETCH;
            end
            S_HALT: halted = 1'b1;
        endcase
    end

    assign bus.alu_op   = alu_op;
    assign bus.ir_load  = ir_load;
    assign bus.pc_write = pc_write;
    assign bus.pc_sel   = pc_sel;
    assign bus.br_sel   = br_sel;
    assign bus.rb_sel   = rb_sel;
    assign bus.rf_we    = rf_we;
    assign bus.wb_sel   = wb_sel;
    assign bus.dm_we    = dm_we;
    assign bus.status_q = status_q;
    assign bus.halted   = halted;

endmodule
